// File: rtl/control_unit_pipe.sv
// Decodes an ARM-subset instruction into ALU opcode and datapath controls, then
// carries the control word through STAGES registers with stall, flush and bubble.
module control_unit_pipe #(
   parameter int STAGES  = 1,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instruction,
   input  logic               in_valid,
   input  logic               stall,
   input  logic               flush,
   output logic               valid,
   output logic [3:0]         cond,
   output logic [3:0]         opcode,
   output logic               AM,
   output logic               S_enable,
   output logic               load_instr,
   output logic               RF_enable,
   output logic               Size_enable,
   output logic               RW_enable,
   output logic               Enable_signal,
   output logic               BL_instr,
   output logic               B_instr,
   output logic               undef
);

   typedef struct packed {
      logic       valid;
      logic [3:0] cond;
      logic [3:0] opcode;
      logic       am;
      logic       s_en;
      logic       load;
      logic       rf_en;
      logic       size_en;
      logic       rw_en;
      logic       mem_en;
      logic       bl;
      logic       b;
      logic       undef;
   } ctrl_t;

   ctrl_t dec_d;
   ctrl_t stage_d [STAGES];
   ctrl_t stage_q [STAGES];

   always_comb begin
      dec_d = '0;
      if (in_valid && (instruction != '0)) begin
         dec_d.valid = 1'b1;
         dec_d.cond  = instruction[31:28];
         case (instruction[27:25])
            3'b000, 3'b001: begin
               dec_d.am = instruction[25];
               case (instruction[24:21])
                  4'b0000: dec_d.opcode = 4'b0110;
                  4'b0001: dec_d.opcode = 4'b1000;
                  4'b0010: dec_d.opcode = 4'b0010;
                  4'b0011: dec_d.opcode = 4'b0100;
                  4'b0100: dec_d.opcode = 4'b0000;
                  4'b0101: dec_d.opcode = 4'b0001;
                  4'b0110: dec_d.opcode = 4'b0011;
                  4'b0111: dec_d.opcode = 4'b0101;
                  4'b1000: dec_d.opcode = 4'b0110;
                  4'b1001: dec_d.opcode = 4'b1000;
                  4'b1010: dec_d.opcode = 4'b0010;
                  4'b1011: dec_d.opcode = 4'b0000;
                  4'b1100: dec_d.opcode = 4'b0111;
                  4'b1101: dec_d.opcode = 4'b1010;
                  4'b1110: dec_d.opcode = 4'b1100;
                  default: dec_d.opcode = 4'b1011;
               endcase
               // Compares only set flags; they never write the register file.
               if (instruction[24:23] == 2'b10) begin
                  dec_d.s_en = 1'b1;
               end else begin
                  dec_d.rf_en = 1'b1;
                  dec_d.s_en  = instruction[20];
               end
            end
            3'b010, 3'b011: begin
               dec_d.opcode  = instruction[23] ? 4'b0000 : 4'b0010;
               dec_d.am      = ~instruction[25];
               dec_d.mem_en  = 1'b1;
               dec_d.size_en = instruction[22];
               dec_d.load    = instruction[20];
               dec_d.rw_en   = ~instruction[20];
               dec_d.rf_en   = instruction[20];
            end
            3'b101: begin
               dec_d.b     = 1'b1;
               dec_d.bl    = instruction[24];
               dec_d.rf_en = instruction[24];
            end
            default: begin
               dec_d.undef = 1'b1;
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign stage_d[gi] = dec_d;
         end else begin : g_next
            assign stage_d[gi] = stage_q[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else if (!stall) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign valid         = stage_q[STAGES-1].valid;
   assign cond          = stage_q[STAGES-1].cond;
   assign opcode        = stage_q[STAGES-1].opcode;
   assign AM            = stage_q[STAGES-1].am;
   assign S_enable      = stage_q[STAGES-1].s_en;
   assign load_instr    = stage_q[STAGES-1].load;
   assign RF_enable     = stage_q[STAGES-1].rf_en;
   assign Size_enable   = stage_q[STAGES-1].size_en;
   assign RW_enable     = stage_q[STAGES-1].rw_en;
   assign Enable_signal = stage_q[STAGES-1].mem_en;
   assign BL_instr      = stage_q[STAGES-1].bl;
   assign B_instr       = stage_q[STAGES-1].b;
   assign undef         = stage_q[STAGES-1].undef;

endmodule

// File: doc/control_unit_pipe.md
# control_unit_pipe

Parametrised successor to the single-cycle control unit. Decodes the ARM-subset instruction word into the ALU opcode and datapath control signals and carries the resulting control word through a configurable number of pipeline registers (ID→EX→MEM), with stall-hold, flush-to-bubble and an undefined-instruction flag. Sits between the instruction register and the EX/MEM stage controls of the pipelined CPU.

## Interface
- `STAGES`, default 1: number of control-word register stages, legal 1–3; output is taken from the last stage.
- `INSTR_W`, default 32: instruction width; fields below assume 32.
- `clk` in 1: rising-edge clock, only clock.
- `reset` in 1: synchronous, active-high; all stages to bubble.
- `instruction` in INSTR_W: instruction from the instruction register.
- `in_valid` in 1: `instruction` is a real instruction this cycle.
- `stall` in 1: hold every stage.
- `flush` in 1: turn every stage into a bubble.
- `valid` out 1: output control word is live.
- `cond` out 4: instruction[31:28] carried with the word.
- `opcode` out 4: ALU operation.
- `AM`, `S_enable`, `load_instr`, `RF_enable`, `Size_enable`, `RW_enable`, `Enable_signal`, `BL_instr`, `B_instr`: out, 1 each.
- `undef` out 1: last-stage word came from an undefined encoding.

## Operation
- Class from instruction[27:25]: 000/001 data-processing (register/immediate), 010/011 load/store (immediate/register offset), 101 branch, all others undefined.
- Data-processing, instruction[24:21] → opcode: 0000→0110 (AND), 0001→1000 (EOR), 0010→0010 (SUB), 0011→0100 (RSB), 0100→0000 (ADD), 0101→0001 (ADC), 0110→0011 (SBC), 0111→0101 (RSC), 1100→0111 (ORR), 1101→1010 (MOV), 1110→1100 (BIC), 1111→1011 (MVN).
- Compare group 1000/1001/1010/1011 (TST/TEQ/CMP/CMN) → 0110/1000/0010/0000. `RF_enable`=0 and `S_enable`=1 regardless of bit 20.
- Other data-processing: `RF_enable`=1; `S_enable`=instruction[20]; `AM`=instruction[25].
- Load/store: opcode = 0000 if U (bit 23)=1, else 0010. `AM`=~instruction[25]. `Enable_signal`=1. `Size_enable`=instruction[22] (1 = byte). `load_instr`=instruction[20]. `RW_enable`=~instruction[20] (1 = store). `RF_enable`=instruction[20]. `S_enable`=0.
- Branch: `B_instr`=1; `BL_instr`=instruction[24]; `RF_enable`=instruction[24] (link write); opcode 0000.
- Undefined class: all control outputs 0, opcode 0000, `undef`=1.
- instruction == 32'h0 or `in_valid`=0: bubble.
- Bubble: `valid`=0, every control output 0, opcode 0000, `cond` 0000, `undef`=0.
- Stage 0 captures the decoded word. Stage k captures stage k−1.
- Priority per edge: `reset` > `flush` > `stall` > advance.
- `flush` clears all stages including the word being captured; the instruction presented that cycle is discarded.
- `stall`: all stages hold; the input is not captured. Upstream must hold `instruction` stable.

## Timing
- Reset (sync): after the first rising edge with `reset`=1, all outputs 0 and `valid`=0. This holds for STAGES cycles minimum after release, until real words propagate.
- Latency: word presented at edge n appears on the outputs after edge n+STAGES−1, i.e. STAGES register delays, with no stall.
- Throughput: one word per unstalled cycle.
- Outputs are purely registered; no combinational path from inputs to outputs.
- Stall for m cycles adds exactly m cycles of latency; no word is lost or duplicated.
- Simultaneous `stall` and `flush`: flush wins; all stages become bubbles.
- Reset mid-stream: every in-flight word is dropped on that edge.

## Test plan
- Reset, STAGES=2: assert `reset` with `in_valid`=1 and an ADD instruction → `valid`=0 and all outputs 0 while asserted. First valid word appears 2 edges after release.
- Opcode sweep: E0810002 (ADD) → opcode 0000, RF_enable=1, AM=0. E2800005 → AM=1. E1500001 (CMP) → opcode 0010, S_enable=1, RF_enable=0. Repeat for all 16 opcode values against the mapping above.
- Memory: E5912004 (LDR imm, U=1) → opcode 0000, load_instr=1, RF_enable=1, Enable_signal=1, Size_enable=0. E5C12004 (STRB) → RW_enable=1, Size_enable=1, load_instr=0.
- Branch: EA000010 → B_instr=1, BL_instr=0. EB000010 → BL_instr=1, RF_enable=1. E6000010 (class 011 ok), E8000000 (class 100) → undef=1, all controls 0.
- Stall, STAGES=3: stream A,B,C,D with `stall` held 2 cycles after B enters → output order A,B,C,D with no duplicates; latency of C,D increased by 2.
- Flush with stall: stream A,B, assert `stall`+`flush` together on the next edge → next output `valid`=0. The following word presented afterward emerges after STAGES cycles.
